conv_layer_ctrl: RTL

Sequencing controller for the `convolution_layer` datapath. It walks a 3x3 window across an IMG_W x IMG_H feature map held in a synchronous-read memory, streaming nine taps per window into the datapath's `data_in`/`valid` inputs. It captures `conv_out` after a fixed datapath latency and presents each result on a ready/valid output port. The block sits between the feature-map buffer and the result writeback path.

---
 rtl/conv_layer_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv_layer_ctrl.sv
// Window sequencer for the convolution_layer datapath: streams nine 3x3 taps per
// window from a synchronous-read feature-map buffer and hands each result out over ready/valid.
module conv_layer_ctrl #(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int CONV_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] conv_data,
   output logic              conv_valid,
   output logic              conv_first,
   input  logic [DATA_W-1:0] conv_result,
   output logic [DATA_W-1:0] out_data,
   output logic [15:0]       out_idx,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int WAIT_LEN = 2 + CONV_LAT;
   localparam int WCNT_W   = $clog2(WAIT_LEN + 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUTPUT, S_DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W-1:0]   next_win_addr;
   logic [15:0]         row;
   logic [15:0]         col;
   logic [3:0]          tap;
   logic [WCNT_W-1:0]   wait_cnt;
   logic                last_col;
   logic                last_win;
   logic                rd_pending;
   logic                rd_first;

   assign last_col = (col == 16'(IMG_W - 3));
   assign last_win = last_col && (row == 16'(IMG_H - 3));

   // Stepping past the last column lands on the next row's first window: +3 from (row, IMG_W-3).
   assign next_win_addr = last_col ? win_addr + ADDR_W'(3) : win_addr + ADDR_W'(1);

   // NOTE: state and outputs use <= so every read in this block sees the pre-edge value.
   // Outputs are registered, so each is loaded on the edge that enters the cycle it belongs to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         win_addr  <= '0;
         row       <= '0;
         col       <= '0;
         tap       <= '0;
         wait_cnt  <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  win_addr  <= base_addr;
                  mem_addr  <= base_addr;
                  mem_rd_en <= 1'b1;
                  tap       <= '0;
                  row       <= '0;
                  col       <= '0;
                  out_idx   <= '0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (tap == 4'd8) begin
                  mem_rd_en <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= S_WAIT;
               end else begin
                  tap      <= tap + 4'd1;
                  mem_addr <= (tap == 4'd2 || tap == 4'd5) ? mem_addr + ROW_STEP
                                                           : mem_addr + ADDR_W'(1);
               end
            end
            S_WAIT: begin
               if (wait_cnt == WCNT_W'(WAIT_LEN - 1)) begin
                  out_data  <= conv_result;
                  out_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            S_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_idx   <= out_idx + 16'd1;
                  if (last_col) begin
                     col <= '0;
                     row <= row + 16'd1;
                  end else begin
                     col <= col + 16'd1;
                  end
                  if (last_win) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     win_addr  <= next_win_addr;
                     mem_addr  <= next_win_addr;
                     mem_rd_en <= 1'b1;
                     tap       <= '0;
                     state     <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read data lands one cycle after the strobe; the tap stage re-times it by one more cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pending <= 1'b0;
         rd_first   <= 1'b0;
         conv_valid <= 1'b0;
         conv_first <= 1'b0;
         conv_data  <= '0;
      end else begin
         rd_pending <= mem_rd_en;
         rd_first   <= mem_rd_en && (tap == 4'd0);
         conv_valid <= rd_pending;
         conv_first <= rd_first;
         if (rd_pending) begin
            conv_data <= mem_rd_data;
         end
      end
   end

endmodule
